glitch_seq_wb: RTL and testbench
================================

Name: glitch_seq_wb

Overview:
- Wishbone-attached clock glitcher, next generation of the single-shot glitcher.
- Adds a parametrised counter width, a programmable pulse train (N pulses separated by a gap) and a hardware trigger input with edge select.
- Sits on the 8-bit Wishbone register bus (adr_i[5:2]) and drives the target clock `clk_out`, muxing `clk_in`, `clk_gla` and `clk_glb` by mode.

Parameters:
- CNT_W, 16, width of the delay/width/gap counters in clk_i cycles (8..16); register bytes above CNT_W read 0 and ignore writes.
- PULSE_W, 8, width of the pulse-count register (1..8).

Ports:
- clk_i  in  1  system/bus clock; all logic is on its rising edge.
- rst_i  in  1  reset, asynchronous assert, active-low.
- dat_i  in  8  Wishbone write data.
- adr_i  in  4  Wishbone word address [5:2].
- dat_o  out  8  Wishbone read data, registered.
- stb_i  in  1  Wishbone strobe.
- we_i  in  1  Wishbone write enable.
- ack_o  out  1  Wishbone acknowledge.
- trig_in  in  1  asynchronous external trigger.
- clk_in  in  1  target clock, passed through outside glitches.
- clk_gla  in  1  alternate glitch clock A.
- clk_glb  in  1  alternate glitch clock B.
- clk_out  out  1  glitched target clock.
- glitch_o  out  1  high while in state WIDTH.

Behaviour:
- Reset (rst_i low): all registers 0, state IDLE, ack_o=0, dat_o=0, glitch_o=0. clk_out then follows clk_in combinationally.
- Bus handshake:
  - ack_o is high for exactly one cycle, in the cycle after a cycle with stb_i=1.
  - Writes take effect on the edge that raises ack_o.
  - dat_o is valid in the cycle ack_o is high.
  - Unmapped addresses ack, read 0 and ignore writes.
- Register map (word address):
  - 0 STATUS. Read: bit0 rdy (IDLE), bit1 armed, bit2 busy. Write: bit0 start, bit1 arm, bit2 abort. Abort has priority over start, and start has priority over arm.
  - 1 MODE: GLITCH_MODE_* encoding from glitch_defs.v; undefined values act as BYPASS.
  - 2/3 DELAY lo/hi. 4/5 WIDTH lo/hi. 6/7 GAP lo/hi.
  - 8 COUNT: number of pulses; 0 is treated as 1.
  - 9 TRIG: bit0 edge (0 rising, 1 falling).
  - 10 SHOTS (see Optional Feature).
- Config registers are writable at any time. A run uses copies latched on entry to DELAY; writes during a run affect the next run only.
- State machine: IDLE, ARMED, DELAY, WIDTH, GAP.
  - IDLE: start goes to DELAY on the next cycle; arm goes to ARMED. Start/arm while not IDLE is ignored.
  - ARMED: on a selected edge of the synchronised trigger, go to DELAY.
  - DELAY: lasts DELAY cycles; DELAY=0 means one cycle, then WIDTH.
  - WIDTH: lasts WIDTH cycles; WIDTH=0 skips the pulse (one cycle, glitch_o stays 0).
  - After WIDTH, if pulses remain go to GAP, else go to IDLE.
  - GAP: lasts GAP cycles (0 means one cycle), then WIDTH.
  - Abort in any state: IDLE on the next edge, with counters cleared.
- Trigger path:
  - trig_in passes through a 2-flop synchroniser and an edge detect.
  - Latency is 3 cycles from trig_in transition to DELAY.
  - Edges outside ARMED are ignored.
- clk_out:
  - Outside WIDTH, it equals clk_in.
  - In WIDTH, by mode: BYPASS=clk_in, ZERO=0, ONE=1, NOT=~clk_in, GLA=clk_gla, GLB=clk_glb.
- Counters are CNT_W-bit down-counters; no wrap beyond their load value.
- Mid-run reset: state returns to IDLE immediately and clk_out reverts to clk_in.

Optional Feature:
- GLITCH_SEQ_SHOT_CNT_EN defined: SHOTS (addr 10) is an 8-bit counter.
  - Increments on each completed (non-aborted) run and saturates at 0xFF.
  - Any write to SHOTS clears it; if a clear coincides with a run completion, the clear wins.
- Undefined: SHOTS reads 0 and writes are ignored. No counter logic is synthesised.

Test Plan:
- After reset, read STATUS -> 0x01; read DELAY/WIDTH/GAP/COUNT -> 0x00. Write/read DELAY_0=0xAB, WIDTH_1=0xCD, MODE=0xDC -> values read back.
- DELAY=8, WIDTH=4, COUNT=1, MODE=ZERO, start -> STATUS reads 0x04; glitch_o high 4 cycles, starting 8 cycles after DELAY entry; clk_out=0 while glitch_o is high; STATUS returns to 0x01.
- COUNT=3, WIDTH=2, GAP=5, MODE=NOT -> 3 glitch_o pulses of 2 cycles, separated by 5-cycle lows; clk_out=~clk_in during pulses.
- TRIG=1 (falling), arm -> STATUS 0x02. Rising trig_in -> no run. Falling trig_in -> DELAY entered 3 cycles later.
- COUNT=4 run, abort during the second GAP -> IDLE next cycle, glitch_o=0, STATUS 0x01. With GLITCH_SEQ_SHOT_CNT_EN, SHOTS is unchanged by this run.
- GLITCH_SEQ_SHOT_CNT_EN: 2 completed runs -> SHOTS=0x02; write SHOTS -> reads 0x00. Without the macro, SHOTS always reads 0x00.

Source files
------------

// File: rtl/glitch_seq_wb.sv
`timescale 1ns/100ps
// glitch_seq_wb -- Wishbone-attached clock glitcher with a programmable pulse
// train and an edge-selectable hardware trigger.
//
// A run is DELAY cycles of wait followed by COUNT pulses of WIDTH cycles, with
// GAP cycles between pulses. While a pulse is active, clk_out is replaced
// according to MODE. At all other times clk_out follows clk_in.
//
// Ports
//   clk_i     system/bus clock. All logic runs on its rising edge.
//   rst_i     asynchronous reset, active low
//   dat_i     Wishbone write data [7:0]
//   adr_i     Wishbone word address [5:2]
//   dat_o     Wishbone read data, registered, valid while ack_o is high
//   stb_i     Wishbone strobe
//   we_i      Wishbone write enable
//   ack_o     Wishbone acknowledge, one cycle after a strobe cycle
//   trig_in   asynchronous external trigger
//   clk_in    target clock, passed through outside glitches
//   clk_gla   alternate glitch clock A
//   clk_glb   alternate glitch clock B
//   clk_out   glitched target clock
//   glitch_o  high while a pulse is being applied
//
// Register map (word address)
//   0 STATUS  rd: {busy, armed, rdy}   wr: bit0 start, bit1 arm, bit2 abort
//   1 MODE    0 BYPASS, 1 ZERO, 2 ONE, 3 NOT, 4 GLA, 5 GLB (glitch_defs.v
//             GLITCH_MODE_* values). Other values act as BYPASS.
//   2/3 DELAY lo/hi, 4/5 WIDTH lo/hi, 6/7 GAP lo/hi
//   8 COUNT   number of pulses. 0 acts as 1.
//   9 TRIG    bit0: 0 rising edge, 1 falling edge
//   10 SHOTS  completed-run counter. Present only when the
//             GLITCH_SEQ_SHOT_CNT_EN macro is defined. Otherwise it reads 0.
//
// State table
//   IDLE  | ready, clk_out = clk_in
//   ARMED | waiting for the selected edge of the synchronised trigger
//   DELAY | counting the pre-glitch delay
//   WIDTH | pulse active (glitch_o high unless WIDTH = 0)
//   GAP   | spacing between consecutive pulses

module glitch_seq_wb #(
    parameter int CNT_W   = 16,
    parameter int PULSE_W = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] dat_i,
    input  logic [3:0] adr_i,
    output logic [7:0] dat_o,
    input  logic       stb_i,
    input  logic       we_i,
    output logic       ack_o,
    input  logic       trig_in,
    input  logic       clk_in,
    input  logic       clk_gla,
    input  logic       clk_glb,
    output logic       clk_out,
    output logic       glitch_o
);

    localparam logic [3:0] A_STATUS   = 4'd0;
    localparam logic [3:0] A_MODE     = 4'd1;
    localparam logic [3:0] A_DELAY_LO = 4'd2;
    localparam logic [3:0] A_DELAY_HI = 4'd3;
    localparam logic [3:0] A_WIDTH_LO = 4'd4;
    localparam logic [3:0] A_WIDTH_HI = 4'd5;
    localparam logic [3:0] A_GAP_LO   = 4'd6;
    localparam logic [3:0] A_GAP_HI   = 4'd7;
    localparam logic [3:0] A_COUNT    = 4'd8;
    localparam logic [3:0] A_TRIG     = 4'd9;
    localparam logic [3:0] A_SHOTS    = 4'd10;

    localparam logic [7:0] GLITCH_MODE_BYPASS = 8'd0;
    localparam logic [7:0] GLITCH_MODE_ZERO   = 8'd1;
    localparam logic [7:0] GLITCH_MODE_ONE    = 8'd2;
    localparam logic [7:0] GLITCH_MODE_NOT    = 8'd3;
    localparam logic [7:0] GLITCH_MODE_GLA    = 8'd4;
    localparam logic [7:0] GLITCH_MODE_GLB    = 8'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DELAY,
        ST_WIDTH,
        ST_GAP
    } state_t;

    state_t state_q, state_d;

    // Configuration registers
    logic [7:0]         mode_r;
    logic [CNT_W-1:0]   delay_r;
    logic [CNT_W-1:0]   width_r;
    logic [CNT_W-1:0]   gap_r;
    logic [PULSE_W-1:0] count_r;
    logic               trig_edge_r;

    // Copies used by the active run
    logic [7:0]         mode_run;
    logic [CNT_W-1:0]   width_run;
    logic [CNT_W-1:0]   gap_run;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PULSE_W-1:0] pulses_q, pulses_d;
    logic               load_run;

    logic               trig_s1, trig_s2, trig_s3;
    logic               trig_hit;

    logic               bus_req, wr_req, wr_status;
    logic               cmd_start, cmd_arm, cmd_abort;
    logic [7:0]         rd_data;
    logic [7:0]         shots_rd;
    logic               pulse_on;
    logic               clk_sel;

    // A DELAY/WIDTH/GAP value of N lasts N cycles, and 0 lasts one cycle.
    // The counter is therefore loaded with N-1, clamped at 0.
    function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    // Byte access into a CNT_W-bit register. Bits above CNT_W read as zero
    // and drop writes.
    function automatic logic [7:0] byte_rd(input logic [CNT_W-1:0] v, input logic hi);
        logic [15:0] w;
        w = 16'(v);
        return hi ? w[15:8] : w[7:0];
    endfunction

    function automatic logic [CNT_W-1:0] byte_wr(input logic [CNT_W-1:0] v,
                                                 input logic hi,
                                                 input logic [7:0] d);
        logic [15:0] w;
        w = 16'(v);
        if (hi) w[15:8] = d;
        else    w[7:0]  = d;
        return w[CNT_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Bus decode. Each strobe is accepted once, in the cycle before ack.
    // ------------------------------------------------------------------
    assign bus_req   = stb_i & ~ack_o;
    assign wr_req    = bus_req & we_i;
    assign wr_status = wr_req && (adr_i == A_STATUS);
    assign cmd_abort = wr_status & dat_i[2];
    assign cmd_start = wr_status & dat_i[0] & ~dat_i[2];
    assign cmd_arm   = wr_status & dat_i[1] & ~dat_i[0] & ~dat_i[2];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_o <= 1'b0;
            dat_o <= 8'h00;
        end else begin
            ack_o <= bus_req;
            dat_o <= bus_req ? rd_data : 8'h00;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mode_r      <= 8'h00;
            delay_r     <= '0;
            width_r     <= '0;
            gap_r       <= '0;
            count_r     <= '0;
            trig_edge_r <= 1'b0;
        end else if (wr_req) begin
            case (adr_i)
                A_MODE:     mode_r      <= dat_i;
                A_DELAY_LO: delay_r     <= byte_wr(delay_r, 1'b0, dat_i);
                A_DELAY_HI: delay_r     <= byte_wr(delay_r, 1'b1, dat_i);
                A_WIDTH_LO: width_r     <= byte_wr(width_r, 1'b0, dat_i);
                A_WIDTH_HI: width_r     <= byte_wr(width_r, 1'b1, dat_i);
                A_GAP_LO:   gap_r       <= byte_wr(gap_r, 1'b0, dat_i);
                A_GAP_HI:   gap_r       <= byte_wr(gap_r, 1'b1, dat_i);
                A_COUNT:    count_r     <= PULSE_W'(dat_i);
                A_TRIG:     trig_edge_r <= dat_i[0];
                default:    ;
            endcase
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (adr_i)
            A_STATUS:   rd_data = {5'b0,
                                   (state_q == ST_DELAY) || (state_q == ST_WIDTH) ||
                                   (state_q == ST_GAP),
                                   state_q == ST_ARMED,
                                   state_q == ST_IDLE};
            A_MODE:     rd_data = mode_r;
            A_DELAY_LO: rd_data = byte_rd(delay_r, 1'b0);
            A_DELAY_HI: rd_data = byte_rd(delay_r, 1'b1);
            A_WIDTH_LO: rd_data = byte_rd(width_r, 1'b0);
            A_WIDTH_HI: rd_data = byte_rd(width_r, 1'b1);
            A_GAP_LO:   rd_data = byte_rd(gap_r, 1'b0);
            A_GAP_HI:   rd_data = byte_rd(gap_r, 1'b1);
            A_COUNT:    rd_data = 8'(count_r);
            A_TRIG:     rd_data = {7'b0, trig_edge_r};
            A_SHOTS:    rd_data = shots_rd;
            default:    rd_data = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // Trigger path. The third flop supplies the previous level for edge
    // detection. From a trig_in transition to DELAY entry takes 3 cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_s3 <= 1'b0;
        end else begin
            trig_s1 <= trig_in;
            trig_s2 <= trig_s1;
            trig_s3 <= trig_s2;
        end
    end

    assign trig_hit = trig_edge_r ? (~trig_s2 & trig_s3) : (trig_s2 & ~trig_s3);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pulses_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pulses_q <= pulses_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mode_run  <= 8'h00;
            width_run <= '0;
            gap_run   <= '0;
        end else if (load_run) begin
            mode_run  <= mode_r;
            width_run <= width_r;
            gap_run   <= gap_r;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pulses_d = pulses_q;
        load_run = 1'b0;

        if (cmd_abort) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            pulses_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ARMED: begin
                    if ((state_q == ST_IDLE && cmd_start) ||
                        (state_q == ST_ARMED && trig_hit)) begin
                        state_d  = ST_DELAY;
                        load_run = 1'b1;
                        cnt_d    = load_val(delay_r);
                        pulses_d = (count_r == '0) ? PULSE_W'(1) : count_r;
                    end else if (state_q == ST_IDLE && cmd_arm) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_DELAY, ST_GAP: begin
                    if (cnt_q == '0) begin
                        state_d = ST_WIDTH;
                        cnt_d   = load_val(width_run);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_WIDTH: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (pulses_q <= PULSE_W'(1)) begin
                        state_d  = ST_IDLE;
                        pulses_d = '0;
                    end else begin
                        state_d  = ST_GAP;
                        pulses_d = pulses_q - PULSE_W'(1);
                        cnt_d    = load_val(gap_run);
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    pulses_d = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Completed-run counter
    // ------------------------------------------------------------------
`ifdef GLITCH_SEQ_SHOT_CNT_EN
    logic [7:0] shots_q;
    logic       run_done;

    assign run_done = !cmd_abort && (state_q == ST_WIDTH) && (cnt_q == '0) &&
                      (pulses_q <= PULSE_W'(1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            shots_q <= 8'h00;
        else if (wr_req && (adr_i == A_SHOTS))
            shots_q <= 8'h00;
        else if (run_done && (shots_q != 8'hFF))
            shots_q <= shots_q + 8'd1;
    end

    assign shots_rd = shots_q;
`else
    assign shots_rd = 8'h00;
`endif

    // ------------------------------------------------------------------
    // Output clock. This mux is purely combinational, so a reset in the
    // middle of a pulse hands clk_in back to the target immediately.
    // ------------------------------------------------------------------
    assign pulse_on = (state_q == ST_WIDTH) && (width_run != '0);

    always_comb begin
        clk_sel = clk_in;
        if (pulse_on) begin
            case (mode_run)
                GLITCH_MODE_BYPASS: clk_sel = clk_in;
                GLITCH_MODE_ZERO:   clk_sel = 1'b0;
                GLITCH_MODE_ONE:    clk_sel = 1'b1;
                GLITCH_MODE_NOT:    clk_sel = ~clk_in;
                GLITCH_MODE_GLA:    clk_sel = clk_gla;
                GLITCH_MODE_GLB:    clk_sel = clk_glb;
                default:            clk_sel = clk_in;
            endcase
        end
    end

    assign clk_out  = clk_sel;
    assign glitch_o = pulse_on;

endmodule

// File: tb/tb_glitch_seq_wb.sv
`timescale 1ns/100ps
module tb_glitch_seq_wb;

    localparam logic [7:0] M_BYPASS = 8'd0;
    localparam logic [7:0] M_ZERO   = 8'd1;
    localparam logic [7:0] M_ONE    = 8'd2;
    localparam logic [7:0] M_NOT    = 8'd3;
    localparam logic [7:0] M_GLA    = 8'd4;
    localparam logic [7:0] M_GLB    = 8'd5;

`ifdef GLITCH_SEQ_SHOT_CNT_EN
    localparam bit SHOT_EN = 1'b1;
`else
    localparam bit SHOT_EN = 1'b0;
`endif

    logic       tb_clk = 1'b0;
    logic       rst_i  = 1'b0;
    logic [7:0] dat_i  = 8'h00;
    logic [3:0] adr_i  = 4'h0;
    logic       stb_i  = 1'b0;
    logic       we_i   = 1'b0;
    logic       trig_in = 1'b0;
    logic       clk_in  = 1'b0;
    logic       clk_gla = 1'b0;
    logic       clk_glb = 1'b0;
    logic [7:0] dat_o;
    logic       ack_o;
    logic       clk_out;
    logic       glitch_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboards: bus read data, per-cycle glitch level, cycle-count results
    logic [7:0] exp_q[$];
    logic       gl_q[$];
    int         num_q[$];

    glitch_seq_wb dut (
        .clk_i    (tb_clk),
        .rst_i    (rst_i),
        .dat_i    (dat_i),
        .adr_i    (adr_i),
        .dat_o    (dat_o),
        .stb_i    (stb_i),
        .we_i     (we_i),
        .ack_o    (ack_o),
        .trig_in  (trig_in),
        .clk_in   (clk_in),
        .clk_gla  (clk_gla),
        .clk_glb  (clk_glb),
        .clk_out  (clk_out),
        .glitch_o (glitch_o)
    );

    // tb_clk edges fall on integer ns. The target clocks toggle on half-integer
    // ns, so values sampled at a tb_clk edge are always settled.
    always #5 tb_clk = ~tb_clk;
    initial begin #0.5; forever #3 clk_in  = ~clk_in;  end
    initial begin #1.5; forever #2 clk_gla = ~clk_gla; end
    initial begin #0.5; forever #4 clk_glb = ~clk_glb; end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic exp_clk(input logic [7:0] m, input logic g);
        if (!g) return clk_in;
        case (m)
            M_ZERO:  return 1'b0;
            M_ONE:   return 1'b1;
            M_NOT:   return ~clk_in;
            M_GLA:   return clk_gla;
            M_GLB:   return clk_glb;
            default: return clk_in;
        endcase
    endfunction

    task automatic bus_cycle(input logic [3:0] a, input logic w, input logic [7:0] d,
                             output logic got_ack, output logic [7:0] rd);
        @(negedge tb_clk);
        adr_i = a; we_i = w; dat_i = d; stb_i = 1'b1;
        @(negedge tb_clk);
        got_ack = ack_o; rd = dat_o;
        stb_i = 1'b0; we_i = 1'b0;
        @(negedge tb_clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        logic ak;
        logic [7:0] v;
        bus_cycle(a, 1'b1, d, ak, v);
    endtask

    task automatic cfg(input logic [15:0] d, input logic [15:0] w, input logic [15:0] g,
                       input logic [7:0] n, input logic [7:0] m);
        wr(4'd2, d[7:0]); wr(4'd3, d[15:8]);
        wr(4'd4, w[7:0]); wr(4'd5, w[15:8]);
        wr(4'd6, g[7:0]); wr(4'd7, g[15:8]);
        wr(4'd8, n);      wr(4'd1, m);
    endtask

    // Issue a read, pop its expected value from the scoreboard, and compare.
    task automatic read_table(input string nm, input logic [3:0] adrs[$], input logic [7:0] exps[$]);
        logic ak;
        logic [7:0] v, e;
        for (int i = 0; i < adrs.size(); i++) begin
            exp_q.push_back(exps[i]);
            bus_cycle(adrs[i], 1'b0, 8'h00, ak, v);
            e = exp_q.pop_front();
            n_cmp++;
            if (ak !== 1'b1 || v !== e) begin
                n_bad++;
                $display("FAIL %s adr=%0d: got ack=%b dat=%h, want ack=1 dat=%h", nm, adrs[i], ak, v, e);
            end
        end
    endtask

    // Start a run with a bus write, or with a falling trig_in when use_trig is
    // set. Then compare glitch_o and clk_out each cycle against a reference
    // timeline. The timeline is built from the run parameters before the
    // stimulus is applied.
    task automatic run_check(input string nm, input int lead, input int d, input int w,
                             input int g, input int n, input logic [7:0] m, input bit use_trig);
        int np;
        int cyc;
        logic ge, ce;
        bit first;
        np = (n == 0) ? 1 : n;
        for (int i = 0; i < lead; i++) gl_q.push_back(1'b0);
        for (int i = 0; i < ((d == 0) ? 1 : d); i++) gl_q.push_back(1'b0);
        for (int p = 0; p < np; p++) begin
            if (w == 0) gl_q.push_back(1'b0);
            else for (int i = 0; i < w; i++) gl_q.push_back(1'b1);
            if (p < np - 1)
                for (int i = 0; i < ((g == 0) ? 1 : g); i++) gl_q.push_back(1'b0);
        end
        for (int i = 0; i < 3; i++) gl_q.push_back(1'b0);

        @(negedge tb_clk);
        if (use_trig) trig_in = 1'b0;
        else begin adr_i = 4'd0; we_i = 1'b1; dat_i = 8'h01; stb_i = 1'b1; end
        first = 1'b1;
        cyc = 0;
        while (gl_q.size() > 0) begin
            @(negedge tb_clk);
            if (first) begin stb_i = 1'b0; we_i = 1'b0; first = 1'b0; end
            ge = gl_q.pop_front();
            ce = exp_clk(m, ge);
            n_cmp++;
            if (glitch_o !== ge) begin
                n_bad++;
                $display("FAIL %s glitch_o cycle %0d: got %b want %b", nm, cyc, glitch_o, ge);
            end
            n_cmp++;
            if (clk_out !== ce) begin
                n_bad++;
                $display("FAIL %s clk_out cycle %0d: got %b want %b", nm, cyc, clk_out, ce);
            end
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        stb_i = 1'b1;
        @(negedge tb_clk);
        @(negedge tb_clk);
        n_cmp++;
        if (ack_o !== 1'b0 || dat_o !== 8'h00 || glitch_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ack=%b dat=%h glitch=%b, want 0 00 0", ack_o, dat_o, glitch_o);
        end
        n_cmp++;
        if (clk_out !== clk_in) begin
            n_bad++;
            $display("FAIL reset_clk_out: got %b want %b", clk_out, clk_in);
        end
        stb_i = 1'b0;
        @(negedge tb_clk);
        rst_i = 1'b1;
        read_table("reset_read", '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8},
                                 '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    endtask

    task automatic test_regs();
        wr(4'd2, 8'hAB);
        wr(4'd5, 8'hCD);
        wr(4'd1, 8'hDC);
        wr(4'd9, 8'hFF);
        wr(4'd11, 8'h55);
        wr(4'd10, 8'h77);
        read_table("regs_read", '{4'd2, 4'd5, 4'd1, 4'd9, 4'd11, 4'd3, 4'd4, 4'd10},
                                '{8'hAB, 8'hCD, 8'hDC, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00});
        wr(4'd9, 8'h00);
    endtask

    task automatic test_single();
        cfg(16'd8, 16'd4, 16'd0, 8'd1, M_ZERO);
        run_check("single", 0, 8, 4, 0, 1, M_ZERO, 1'b0);
        read_table("single_status", '{4'd0}, '{8'h01});
    endtask

    task automatic test_train();
        cfg(16'd2, 16'd2, 16'd5, 8'd3, M_NOT);
        run_check("train", 0, 2, 2, 5, 3, M_NOT, 1'b0);
        cfg(16'd0, 16'd1, 16'd0, 8'd2, M_GLB);
        run_check("zero_gap", 0, 0, 1, 0, 2, M_GLB, 1'b0);
        cfg(16'd0, 16'd0, 16'd0, 8'd0, M_GLA);
        run_check("zero_width", 0, 0, 0, 0, 0, M_GLA, 1'b0);
        read_table("train_status", '{4'd0}, '{8'h01});
    endtask

    task automatic test_trigger();
        cfg(16'd1, 16'd3, 16'd0, 8'd1, M_ONE);
        wr(4'd9, 8'h01);
        wr(4'd0, 8'h02);
        read_table("trig_armed", '{4'd0}, '{8'h02});
        @(negedge tb_clk);
        trig_in = 1'b1;
        repeat (6) @(negedge tb_clk);
        read_table("trig_rise_ignored", '{4'd0}, '{8'h02});
        run_check("trig_fall", 2, 1, 3, 0, 1, M_ONE, 1'b1);
        read_table("trig_done", '{4'd0}, '{8'h01});
        trig_in = 1'b1;
        repeat (5) @(negedge tb_clk);
        trig_in = 1'b0;
        repeat (5) @(negedge tb_clk);
        read_table("trig_idle_ignored", '{4'd0}, '{8'h01});
        wr(4'd9, 8'h00);
    endtask

    // A run in progress uses its latched config, and a second start is ignored.
    task automatic test_busy();
        int wait_cyc;
        int high_cyc;
        cfg(16'd20, 16'd3, 16'd0, 8'd1, M_ZERO);
        wr(4'd0, 8'h01);
        read_table("busy_status", '{4'd0}, '{8'h04});
        wr(4'd4, 8'd9);
        wr(4'd0, 8'h01);
        num_q.push_back(10);
        num_q.push_back(3);
        wait_cyc = 0;
        while (wait_cyc < 40) begin
            @(negedge tb_clk);
            wait_cyc++;
            if (glitch_o === 1'b1) break;
        end
        high_cyc = 0;
        while (glitch_o === 1'b1 && high_cyc < 20) begin
            high_cyc++;
            @(negedge tb_clk);
        end
        n_cmp++;
        if (wait_cyc !== num_q.pop_front()) begin
            n_bad++;
            $display("FAIL busy_delay: got %0d cycles to pulse, want 10", wait_cyc);
        end
        n_cmp++;
        if (high_cyc !== num_q.pop_front()) begin
            n_bad++;
            $display("FAIL busy_width: got %0d pulse cycles, want 3", high_cyc);
        end
        read_table("busy_done", '{4'd0}, '{8'h01});
    endtask

    task automatic test_abort();
        logic [7:0] shots_exp;
        wr(4'd10, 8'h00);
        cfg(16'd1, 16'd2, 16'd6, 8'd1, M_ONE);
        run_check("abort_pre_run", 0, 1, 2, 6, 1, M_ONE, 1'b0);
        wr(4'd8, 8'd4);
        @(negedge tb_clk);
        adr_i = 4'd0; we_i = 1'b1; dat_i = 8'h01; stb_i = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            @(negedge tb_clk);
            if (i == 1) begin stb_i = 1'b0; we_i = 1'b0; end
            if (i == 10) begin
                n_cmp++;
                if (glitch_o !== 1'b1) begin
                    n_bad++;
                    $display("FAIL abort_second_pulse: got glitch_o=%b want 1", glitch_o);
                end
            end
        end
        adr_i = 4'd0; we_i = 1'b1; dat_i = 8'h04; stb_i = 1'b1;
        @(negedge tb_clk);
        stb_i = 1'b0; we_i = 1'b0;
        n_cmp++;
        if (glitch_o !== 1'b0 || clk_out !== clk_in) begin
            n_bad++;
            $display("FAIL abort_outputs: got glitch_o=%b clk_out=%b, want 0 and %b", glitch_o, clk_out, clk_in);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge tb_clk);
            n_cmp++;
            if (glitch_o !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_quiet cycle %0d: got glitch_o=%b want 0", i, glitch_o);
            end
        end
        shots_exp = SHOT_EN ? 8'h01 : 8'h00;
        read_table("abort_status", '{4'd0, 4'd10}, '{8'h01, shots_exp});
    endtask

    task automatic test_shots();
        logic [7:0] shots_exp;
        wr(4'd10, 8'h00);
        cfg(16'd0, 16'd1, 16'd0, 8'd1, M_ZERO);
        run_check("shots_run1", 0, 0, 1, 0, 1, M_ZERO, 1'b0);
        cfg(16'd0, 16'd2, 16'd0, 8'd1, 8'hDC);
        run_check("shots_run2", 0, 0, 2, 0, 1, 8'hDC, 1'b0);
        shots_exp = SHOT_EN ? 8'h02 : 8'h00;
        read_table("shots_count", '{4'd10}, '{shots_exp});
        wr(4'd10, 8'h5A);
        read_table("shots_clear", '{4'd10}, '{8'h00});
    endtask

    task automatic test_midrun_reset();
        cfg(16'd0, 16'd10, 16'd0, 8'd1, M_ZERO);
        wr(4'd0, 8'h01);
        n_cmp++;
        if (glitch_o !== 1'b1 || clk_out !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun_active: got glitch_o=%b clk_out=%b, want 1 0", glitch_o, clk_out);
        end
        #2;
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if (glitch_o !== 1'b0 || clk_out !== clk_in) begin
            n_bad++;
            $display("FAIL midrun_reset: got glitch_o=%b clk_out=%b, want 0 and %b", glitch_o, clk_out, clk_in);
        end
        @(negedge tb_clk);
        rst_i = 1'b1;
        read_table("midrun_after", '{4'd0, 4'd4}, '{8'h01, 8'h00});
    endtask

    initial begin
        test_reset();
        test_regs();
        test_single();
        test_train();
        test_trigger();
        test_busy();
        test_abort();
        test_shots();
        test_midrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
